// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response voter and the BCD display stage.
package puf_pkg;

    localparam int RESP_W  = 16;
    localparam int NIBBLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        GAP,
        DONE
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/puf_bit_counter.sv
// Per-bit ones counter with majority and disagreement flags over one evaluation.
module puf_bit_counter #(
    parameter int NUM_EVALS = 15,
    parameter int CNT_W     = $clog2(NUM_EVALS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc_en,
    input  logic             bit_in,
    output logic [CNT_W-1:0] count,
    output logic             majority,
    output logic             unstable
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc_en) begin
            r_count <= r_count + CNT_W'(bit_in);
        end
    end

    assign count    = r_count;
    assign majority = (r_count > CNT_W'(NUM_EVALS / 2));
    assign unstable = (r_count != '0) && (r_count != CNT_W'(NUM_EVALS));

endmodule

// File: rtl/puf_response_voter.sv
// Samples the RO PUF bits several times and majority-votes them into one response.
module puf_response_voter
    import puf_pkg::*;
#(
    parameter  int NUM_EVALS     = 15,
    parameter  int SETTLE_CYCLES = 1024,
    parameter  int SAMPLE_GAP    = 64,
    localparam int CNT_W         = $clog2(NUM_EVALS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RESP_W-1:0] raw_resp,
    output logic [RESP_W-1:0] response,
    output logic              resp_valid,
    output logic              busy,
    output logic [RESP_W-1:0] unstable_mask
);

    localparam int TMR_W = $clog2(max2(SETTLE_CYCLES, SAMPLE_GAP) + 1);
    localparam int IDX_W = $clog2(NUM_EVALS + 1);

    if (((NUM_EVALS % 2) == 0) || (NUM_EVALS < 3)) begin : g_bad_evals
        $error("NUM_EVALS must be odd and at least 3");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (SAMPLE_GAP < 1) begin : g_bad_gap
        $error("SAMPLE_GAP must be at least 1");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TMR_W-1:0]    r_timer;
    logic [IDX_W-1:0]    r_idx;
    logic [RESP_W-1:0]   r_sync1;
    logic [RESP_W-1:0]   r_sync2;
    logic [RESP_W-1:0]   r_response;
    logic [RESP_W-1:0]   r_unstable;
    logic [RESP_W-1:0]   w_maj;
    logic [RESP_W-1:0]   w_unst;
    logic [RESP_W*CNT_W-1:0] w_unused_cnt;
    logic                w_accept;
    logic                w_sample;
    logic                w_last;
    logic                w_settle_done;
    logic                w_gap_done;

    assign w_accept      = (r_state == IDLE) && start;
    assign w_sample      = (r_state == SAMPLE);
    assign w_last        = (r_idx == IDX_W'(NUM_EVALS - 1));
    assign w_settle_done = (r_timer == TMR_W'(SETTLE_CYCLES - 1));
    assign w_gap_done    = (r_timer == TMR_W'(SAMPLE_GAP - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_resp;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (SETTLE_CYCLES == 1) ? SAMPLE : SETTLE;
                end
            end
            SETTLE: begin
                if (w_settle_done) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = (SAMPLE_GAP == 1) ? SAMPLE : GAP;
                end
            end
            GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = SAMPLE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Timer reads 1 in the first cycle after the start or sample it measures from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_accept || w_sample) begin
            r_timer <= TMR_W'(1);
        end else if ((r_state == SETTLE) || (r_state == GAP)) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if (w_sample) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    for (genvar i = 0; i < RESP_W; i++) begin : g_bit
        puf_bit_counter #(
            .NUM_EVALS (NUM_EVALS),
            .CNT_W     (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .clr      (w_accept),
            .inc_en   (w_sample),
            .bit_in   (r_sync2[i]),
            .count    (w_unused_cnt[i*CNT_W +: CNT_W]),
            .majority (w_maj[i]),
            .unstable (w_unst[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_response <= '0;
            r_unstable <= '0;
        end else if (r_state == DONE) begin
            r_response <= w_maj;
            r_unstable <= w_unst;
        end
    end

    // The fresh vote is shown during DONE and held from the registers afterwards.
    assign response      = (r_state == DONE) ? w_maj : r_response;
    assign unstable_mask = (r_state == DONE) ? w_unst : r_unstable;
    assign resp_valid    = (r_state == DONE);
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_puf_response_voter.sv
// Directed and randomized checks of puf_response_voter against a per-sample vote model.
module tb_puf_response_voter;

    localparam int N   = 5;
    localparam int S   = 8;
    localparam int G   = 4;
    localparam int LAT = S + (N - 1) * G + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] raw_resp;
    logic [15:0] response;
    logic [15:0] unstable_mask;
    logic        resp_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] rawc [0:LAT];
    logic [15:0] exp_resp;
    logic [15:0] exp_mask;
    logic [15:0] prev_resp;
    logic [15:0] prev_mask;

    puf_response_voter #(
        .NUM_EVALS     (N),
        .SETTLE_CYCLES (S),
        .SAMPLE_GAP    (G)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .raw_resp      (raw_resp),
        .response      (response),
        .resp_valid    (resp_valid),
        .busy          (busy),
        .unstable_mask (unstable_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Raw value seen by sample k is the one driven two cycles earlier (synchronizer).
    task automatic model();
        int cnt;
        for (int b = 0; b < 16; b++) begin
            cnt = 0;
            for (int k = 0; k < N; k++) begin
                cnt += int'(rawc[S + k * G - 2][b]);
            end
            exp_resp[b] = (cnt > N / 2);
            exp_mask[b] = (cnt != 0) && (cnt != N);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int c = 0; c <= LAT; c++) rawc[c] = v;
    endtask

    task automatic fill_noisy(input logic [15:0] base);
        for (int c = 0; c <= LAT; c++) begin
            rawc[c] = base ^ 16'($urandom & $urandom & $urandom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_eval(input bit poke);
        model();
        for (int c = 0; c <= LAT; c++) begin
            raw_resp = rawc[c];
            start    = (c == 0) || (poke && (c == 10 || c == LAT));
            chk($sformatf("busy c%0d", c), 32'(busy), 32'((c >= 1) ? 1 : 0));
            chk($sformatf("valid c%0d", c), 32'(resp_valid), 32'((c == LAT) ? 1 : 0));
            chk($sformatf("resp c%0d", c), 32'(response),
                32'((c == LAT) ? exp_resp : prev_resp));
            chk($sformatf("mask c%0d", c), 32'(unstable_mask),
                32'((c == LAT) ? exp_mask : prev_mask));
            step();
        end
        start     = 1'b0;
        prev_resp = exp_resp;
        prev_mask = exp_mask;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        raw_resp  = 16'h0000;
        prev_resp = 16'h0000;
        prev_mask = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst resp", 32'(response), 32'h0);
        chk("rst mask", 32'(unstable_mask), 32'h0);
        chk("rst valid", 32'(resp_valid), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step();

        fill(16'hA5C3);
        run_eval(1'b0);
        chk("t1 resp", 32'(prev_resp), 32'hA5C3);

        fill(16'h0000);
        rawc[S + 1 * G - 2][0] = 1'b1;
        rawc[S + 3 * G - 2][0] = 1'b1;
        run_eval(1'b0);
        chk("t2 mask", 32'(prev_mask), 32'h0001);

        for (int k = 0; k < N; k += 2) rawc[S + k * G - 2][15] = 1'b1;
        run_eval(1'b0);
        chk("t3 resp", 32'(prev_resp), 32'h8000);
        chk("t3 mask", 32'(prev_mask), 32'h8001);

        step();
        fill(16'h1234);
        run_eval(1'b1);
        for (int c = LAT + 1; c <= LAT + 14; c++) begin
            chk($sformatf("idle valid c%0d", c), 32'(resp_valid), 32'h0);
            chk($sformatf("idle busy c%0d", c), 32'(busy), 32'h0);
            chk($sformatf("idle resp c%0d", c), 32'(response), 32'h1234);
            step();
        end

        fill(16'hFFFF);
        for (int c = 0; c < 12; c++) begin
            raw_resp = rawc[c];
            start    = (c == 0);
            step();
        end
        chk("pre-rst busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid rst resp", 32'(response), 32'h0);
        chk("mid rst mask", 32'(unstable_mask), 32'h0);
        chk("mid rst valid", 32'(resp_valid), 32'h0);
        chk("mid rst busy", 32'(busy), 32'h0);
        step();
        rst = 1'b0;
        step();
        prev_resp = 16'h0000;
        prev_mask = 16'h0000;
        run_eval(1'b0);
        chk("t5 resp", 32'(prev_resp), 32'hFFFF);

        fill(16'h5A5A);
        run_eval(1'b0);
        chk("t6 resp", 32'(prev_resp), 32'h5A5A);

        for (int r = 0; r < 3; r++) begin
            fill_noisy(16'($urandom));
            run_eval(1'b0);
        end
        for (int c = 0; c <= LAT; c++) rawc[c] = 16'($urandom);
        run_eval(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
